// File: rtl/multi_cycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multi_cycle_ctrl : miniRV multi-cycle control FSM (F/D/E/M/W + trap)   |
// | Revision 1.0                                                           |
// +----------------------------------------------------------------------+
module multi_cycle_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] opcode,
  output logic       imem_req,
  input  logic       imem_ack,
  output logic       dmem_req,
  output logic       dmem_we,
  input  logic       dmem_ack,
  output logic       ir_we,
  output logic       pc_we,
  output logic       pc_sel,
  output logic       alu_src,
  output logic       rf_we,
  output logic [1:0] wb_sel,
  output logic       illegal,
  output logic       timeout,
  output logic [2:0] state
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    C_NONE  = 3'd0,
    C_R     = 3'd1,
    C_I     = 3'd2,
    C_LOAD  = 3'd3,
    C_JALR  = 3'd4,
    C_STORE = 3'd5,
    C_U     = 3'd6
  } class_t;

  state_t          r_state;
  state_t          w_next;
  class_t          r_class;
  class_t          w_class;
  logic [WD_W-1:0] r_wd;
  logic            r_illegal;
  logic            r_timeout;
  logic            w_req;
  logic            w_ack;
  logic            w_wd_expire;

  always_comb begin
    w_class = C_NONE;
    case (opcode)
      7'b0110011: w_class = C_R;
      7'b0010011: w_class = C_I;
      7'b0000011: w_class = C_LOAD;
      7'b1100111: w_class = C_JALR;
      7'b0100011: w_class = C_STORE;
      7'b0110111: w_class = C_U;
      default:    w_class = C_NONE;
    endcase
  end

  assign w_req       = (r_state == S_FETCH) || (r_state == S_MEM);
  assign w_ack       = (r_state == S_FETCH) ? imem_ack :
                       (r_state == S_MEM)   ? dmem_ack : 1'b0;
  // Ack in the final allowed req cycle still completes the transfer.
  assign w_wd_expire = w_req && !w_ack && (r_wd == WD_W'(TIMEOUT - 1));

  always_comb begin
    w_next   = r_state;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 1'b0;
    alu_src  = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we  = 1'b1;
          w_next = S_DECODE;
        end else if (w_wd_expire) begin
          w_next = S_TRAP;
        end
      end
      S_DECODE: begin
        w_next = (w_class == C_NONE) ? S_TRAP : S_EXEC;
      end
      S_EXEC: begin
        alu_src = (r_class != C_R);
        w_next  = (r_class == C_LOAD || r_class == C_STORE) ? S_MEM : S_WB;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (r_class == C_STORE);
        if (dmem_ack) begin
          if (r_class == C_STORE) begin
            pc_we  = 1'b1;
            w_next = start ? S_FETCH : S_IDLE;
          end else begin
            w_next = S_WB;
          end
        end else if (w_wd_expire) begin
          w_next = S_TRAP;
        end
      end
      S_WB: begin
        pc_we  = 1'b1;
        rf_we  = (r_class != C_STORE);
        pc_sel = (r_class == C_JALR);
        case (r_class)
          C_LOAD:  wb_sel = 2'b01;
          C_JALR:  wb_sel = 2'b10;
          C_U:     wb_sel = 2'b11;
          default: wb_sel = 2'b00;
        endcase
        w_next = start ? S_FETCH : S_IDLE;
      end
      S_TRAP: begin
        w_next = S_TRAP;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_class   <= C_NONE;
      r_wd      <= '0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_class <= w_class;
      if (r_state == S_DECODE && w_class == C_NONE) r_illegal <= 1'b1;
      if (w_wd_expire) r_timeout <= 1'b1;
      if ((w_next == S_FETCH || w_next == S_MEM) && (w_next != r_state)) begin
        r_wd <= '0;
      end else if (w_req && !w_ack && !w_wd_expire) begin
        r_wd <= r_wd + 1'b1;
      end
    end
  end

  assign illegal = r_illegal;
  assign timeout = r_timeout;
  assign state   = r_state;

endmodule
`default_nettype wire
